// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - read-modify-write store merge FSM for SB/SH/SW stores.
// Optional misaligned-store trap enabled by defining STORE_MISALIGN_TRAP_EN.
module store_merge_unit #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_op,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  localparam logic [1:0] OP_INV = 2'b00;
  localparam logic [1:0] OP_SB  = 2'b01;
  localparam logic [1:0] OP_SH  = 2'b10;
  localparam logic [1:0] OP_SW  = 2'b11;
  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  wait_cnt;
  logic [31:0] merged;
  logic [31:0] aligned_q;
  logic [31:0] start_aligned;
  logic        trap;

  assign aligned_q     = {addr_q[31:2], 2'b00};
  assign start_aligned = {addr[31:2], 2'b00};

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap = ((store_op == OP_SH) && addr[0]) || ((store_op == OP_SW) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Replace only the addressed lane of the word read back from memory.
  always_comb begin
    merged = mem_rdata;
    case (op_q)
      OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8]  = data_q[7:0];
      OP_SH:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      OP_SW:   merged = data_q;
      default: merged = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      wait_cnt  <= 3'd0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 2'b00;
    end else begin
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      err       <= 2'b00;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= store_op;
            addr_q <= addr;
            data_q <= reg_data;
            busy   <= 1'b1;
            if (store_op == OP_INV) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 2'b01;
            end else if (trap) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 2'b10;
            end else if (store_op == OP_SW) begin
              state     <= WRITE;
              mem_addr  <= start_aligned;
              mem_wdata <= reg_data;
              mem_wr    <= 1'b1;
            end else begin
              state    <= READ;
              mem_addr <= start_aligned;
              wait_cnt <= 3'd1;
            end
          end
        end
        READ: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= MERGE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
            mem_addr <= aligned_q;
          end
        end
        MERGE: begin
          state     <= WRITE;
          mem_addr  <= aligned_q;
          mem_wdata <= merged;
          mem_wr    <= 1'b1;
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 1, meaning memory read latency in cycles (legal range 1..7).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request a store; sampled only in IDLE.
REQ-005 The block SHALL have port store_op  input  2  store type: 00 invalid, 01 SB, 10 SH, 11 SW.
REQ-006 The block SHALL have port addr  input  32  byte address of the store.
REQ-007 The block SHALL have port reg_data  input  32  register value to store; SB uses [7:0], SH uses [15:0].
REQ-008 The block SHALL have port mem_rdata  input  32  word read from memory.
REQ-009 The block SHALL have port mem_addr  output  32  word-aligned memory address.
REQ-010 The block SHALL have port mem_wdata  output  32  word written to memory.
REQ-011 The block SHALL have port mem_wr  output  1  memory write strobe, one cycle.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port err  output  2  status valid with done: 00 ok, 01 invalid op, 10 misaligned.

Function
REQ-015 FSM states SHALL be IDLE, READ, MERGE, WRITE, DONE.
REQ-016 In IDLE with start=1, store_op, addr and reg_data SHALL be latched; later input changes have no effect.
REQ-017 Transitions from IDLE on start: SW -> WRITE; SB/SH -> READ; op 00 -> DONE with err=01, no memory access.
REQ-018 READ SHALL hold mem_addr={addr[31:2],2'b00}, mem_wr=0, for exactly READ_WAIT cycles, then go to MERGE.
REQ-019 MERGE SHALL register mem_rdata and replace the addressed lane: SB byte k=addr[1:0] at bits [8k+7:8k]; SH half h=addr[1] at bits [16h+15:16h]; other bits unchanged.
REQ-020 WRITE SHALL drive mem_addr (aligned), mem_wdata (merged word, or reg_data for SW), mem_wr=1 for exactly one cycle, then go to DONE.
REQ-021 DONE SHALL assert done=1 for one cycle with err valid, then go to IDLE; err SHALL be 00 in all other cycles.
REQ-022 Latency from start cycle: SW done at cycle +2; SB/SH done at cycle READ_WAIT+3; invalid op done at cycle +1.
REQ-023 start asserted while busy=1 SHALL be ignored, not queued.
REQ-024 Outside READ/WRITE, mem_addr and mem_wdata SHALL be 0 and mem_wr SHALL be 0.
REQ-025 A new start SHALL be accepted in the IDLE cycle immediately after DONE (back-to-back allowed).

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, err=00, and clear all latched operands.
REQ-027 Reset asserted mid-operation (including during WRITE) SHALL deassert mem_wr without waiting for a clock edge; the pending store is discarded.
REQ-028 After reset_n returns to 1, the first accepted start SHALL be on a rising edge with start=1.

Configuration
REQ-029 Macro STORE_MISALIGN_TRAP_EN SHALL, when defined, make SH with addr[0]=1 or SW with addr[1:0]!=00 go IDLE -> DONE with err=10 and no memory access.
REQ-030 Without STORE_MISALIGN_TRAP_EN, addr[0] SHALL be ignored for SH and addr[1:0] ignored for SW, the store proceeds aligned, and err=10 SHALL never occur.

Verification
REQ-031 SW, addr=0x0000_0104, reg_data=0xDEAD_BEEF -> cycle+1 mem_wr=1, mem_addr=0x104, mem_wdata=0xDEADBEEF; done at cycle+2, err=00.
REQ-032 SB, addr=0x0000_0013, reg_data=0x0000_00AB, mem_rdata=0x1122_3344, READ_WAIT=1 -> mem_wdata=0xAB22_3344 at mem_addr=0x10; done at cycle+4.
REQ-033 SH, addr=0x0000_0022, reg_data=0xFFFF_5566, mem_rdata=0xAABB_CCDD -> mem_wdata=0x5566_CCDD at mem_addr=0x20.
REQ-034 store_op=00 with start -> done at cycle+1, err=01, mem_wr never asserted; start pulses during a busy SB -> ignored, exactly one write.
REQ-035 SW addr=0x0000_0102: with STORE_MISALIGN_TRAP_EN -> err=10, no write; without -> write 0x100.
REQ-036 reset_n=0 asserted during WRITE of an SB -> mem_wr falls same cycle, busy=0; next SW after release completes normally.
